mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter BW_ADDRESS, default 32, address width.
REQ-002 SHALL have parameter BW_PROCESSOR_BLOCK, default 64, memory data/block width.
REQ-003 SHALL have parameter BW_STALL_CNT, default 16, stall counter width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 clock; rst_n input 1 async active-low reset.
REQ-005 i_imem_valid in 1, o_imem_ready out 1, i_imem_addr in BW_ADDRESS, o_imem_rdata out BW_PROCESSOR_BLOCK: fetch-side read port.
REQ-006 i_dmem_valid in 1, o_dmem_ready out 1, i_dmem_wen in 1, i_dmem_addr in BW_ADDRESS, i_dmem_wdata in BW_PROCESSOR_BLOCK, o_dmem_rdata out BW_PROCESSOR_BLOCK: data-side read/write port.
REQ-007 o_mem_valid out 1, i_mem_ready in 1, o_mem_wen out 1, o_mem_addr out BW_ADDRESS, o_mem_wdata out BW_PROCESSOR_BLOCK, i_mem_rdata in BW_PROCESSOR_BLOCK: shared memory port.
REQ-008 o_stall_cnt out BW_STALL_CNT: saturating count of requester wait cycles.

Function
REQ-009 SHALL implement states ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D.
REQ-010 Requesters hold valid and payload stable until their ready; a transaction completes in the cycle o_mem_valid && i_mem_ready.
REQ-011 In ARB_IDLE, the arbiter SHALL pick a winner among asserted valids, register its addr/wen/wdata (I side: wen=0, wdata=0) into o_mem_*, and set o_mem_valid=1 from the next cycle (one-cycle arbitration latency).
REQ-012 In a grant state, o_mem_valid and o_mem_addr/wen/wdata SHALL stay constant until i_mem_ready.
REQ-013 On completion, the granted side's ready SHALL be 1 for exactly that cycle, with its rdata = i_mem_rdata combinationally; the other side's ready SHALL be 0.
REQ-014 On completion, the just-served requester's valid SHALL be ignored; if the other requester is valid, the block SHALL grant it directly (o_mem_valid stays 1, new payload registered, no idle cycle), else it SHALL return to ARB_IDLE with o_mem_valid=0.
REQ-015 o_imem_ready/o_dmem_ready SHALL be 0 in all non-completion cycles; rdata outputs are don't-care when ready=0 but SHALL equal i_mem_rdata.
REQ-016 A write (wen=1) completion SHALL still pulse o_dmem_ready; o_dmem_rdata is ignored by the requester.
REQ-017 o_stall_cnt SHALL increment by 1 per cycle in which any requester has valid=1 and is not the currently granted requester, saturating at all-ones; one cycle counts once even if both sides wait.
REQ-018 A register last_grant SHALL record the side of the most recent grant.

Reset
REQ-019 On rst_n low: state=ARB_IDLE, o_mem_valid=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0, o_stall_cnt=0, last_grant=D; ready outputs 0.
REQ-020 Reset mid-transaction SHALL drop the transaction without any ready pulse; requests still valid after reset release are re-arbitrated from ARB_IDLE.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN: when defined, an ARB_IDLE tie SHALL go to the side opposite last_grant (first tie after reset goes to I).
REQ-022 When undefined, an ARB_IDLE tie SHALL always go to D (fixed data priority); REQ-014 back-to-back handoff applies in both modes.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum (ARB_IDLE/ARB_GRANT_I/ARB_GRANT_D) and the requester-id typedef (REQ_I, REQ_D).
REQ-024 A combinational sub-module arb_pick (inputs: both valids, last_grant; output: winner id, any-valid) SHALL contain the priority/round-robin choice; all state lives in mem_port_arbiter.

Verification
REQ-025 Single I read: i_imem_valid=1, addr 0x40 at cycle 0; i_mem_ready=1 at cycle 3 with rdata 0xDEADBEEF00000001 -> o_mem_valid=1 cycles 1-3, addr 0x40, wen 0; o_imem_ready=1 only at cycle 3 with that rdata; o_mem_valid=0 at cycle 4.
REQ-026 Macro off, both valid at cycle 0 (I addr 0x80; D write addr 0x100, wdata 0x55); mem ready at cycles 2 and 3 -> D granted cycles 1-2 with wen=1; I granted cycle 3 back-to-back; o_stall_cnt=3 at cycle 4.
REQ-027 Macro on, both valid continuously after reset, i_mem_ready tied 1 -> grant order I, D, I, D, one completion per cycle after the first arbitration cycle.
REQ-028 i_mem_ready tied 1, single requester issuing new requests -> each transaction takes 2 cycles (ARB_IDLE then grant), o_mem_valid toggles 0/1.
REQ-029 Assert rst_n low at cycle 2 of a D read with ready never given -> all outputs at reset values in that cycle, no o_dmem_ready pulse; after release, re-arbitration one cycle later.
REQ-030 BW_STALL_CNT=4, I held waiting behind a D transaction for 20 cycles -> o_stall_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // The requester on the opposite side of the given one.
  function automatic req_id_t other_side(input req_id_t side);
    return (side == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Build option ARB_ROUND_ROBIN_EN: when defined, a tie goes to the side
// opposite the last grant; otherwise a tie always goes to the data side.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_valid,
  input  logic    d_valid,
  input  req_id_t last_grant,
  output req_id_t winner,
  output logic    any_valid
);

  assign any_valid = i_valid | d_valid;

  // Single requester wins outright; a tie is resolved by the build option.
  always_comb begin
    winner = REQ_D;
    if (i_valid && d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = other_side(last_grant);
`else
      winner = REQ_D;
`endif
    end else if (i_valid) begin
      winner = REQ_I;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the port consumed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch (I) read port and a data (D) read/write port onto one
// shared memory port. One cycle of arbitration latency from idle, direct
// handoff to the other side on completion, saturating wait-cycle counter.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking in idle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BW_ADDRESS         = 32,
  parameter int BW_PROCESSOR_BLOCK = 64,
  parameter int BW_STALL_CNT       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_imem_valid,
  output logic                          o_imem_ready,
  input  logic [BW_ADDRESS-1:0]         i_imem_addr,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_imem_rdata,
  input  logic                          i_dmem_valid,
  output logic                          o_dmem_ready,
  input  logic                          i_dmem_wen,
  input  logic [BW_ADDRESS-1:0]         i_dmem_addr,
  input  logic [BW_PROCESSOR_BLOCK-1:0] i_dmem_wdata,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_dmem_rdata,
  output logic                          o_mem_valid,
  input  logic                          i_mem_ready,
  output logic                          o_mem_wen,
  output logic [BW_ADDRESS-1:0]         o_mem_addr,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_mem_wdata,
  input  logic [BW_PROCESSOR_BLOCK-1:0] i_mem_rdata,
  output logic [BW_STALL_CNT-1:0]       o_stall_cnt
);

  arb_state_t                    state_reg, state_next;
  req_id_t                       last_grant_reg, last_grant_next;
  logic                          mem_valid_reg, mem_valid_next;
  logic                          mem_wen_reg, mem_wen_next;
  logic [BW_ADDRESS-1:0]         mem_addr_reg, mem_addr_next;
  logic [BW_PROCESSOR_BLOCK-1:0] mem_wdata_reg, mem_wdata_next;
  logic [BW_STALL_CNT-1:0]       stall_cnt_reg, stall_cnt_next;

  req_id_t pick_winner;
  logic    pick_any;
  logic    done;
  logic    grant_i;
  logic    grant_d;
  logic    waiting;

  arb_pick u_arb_pick (
    .i_valid    (i_imem_valid),
    .d_valid    (i_dmem_valid),
    .last_grant (last_grant_reg),
    .winner     (pick_winner),
    .any_valid  (pick_any)
  );

  // A transaction completes when the registered request meets memory ready.
  assign done = mem_valid_reg && i_mem_ready;

  assign o_imem_ready = done && (state_reg == ARB_GRANT_I);
  assign o_dmem_ready = done && (state_reg == ARB_GRANT_D);
  assign o_imem_rdata = i_mem_rdata;
  assign o_dmem_rdata = i_mem_rdata;
  assign o_mem_valid  = mem_valid_reg;
  assign o_mem_wen    = mem_wen_reg;
  assign o_mem_addr   = mem_addr_reg;
  assign o_mem_wdata  = mem_wdata_reg;
  assign o_stall_cnt  = stall_cnt_reg;

  // Next-state, grant decision and payload capture; the served side's valid
  // is ignored on completion so the other side gets the port next.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_valid_next  = mem_valid_reg;
    mem_wen_next    = mem_wen_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_i = (pick_winner == REQ_I);
          grant_d = (pick_winner == REQ_D);
        end
      end
      ARB_GRANT_I: begin
        if (done) begin
          grant_d = i_dmem_valid;
          if (!i_dmem_valid) begin
            state_next     = ARB_IDLE;
            mem_valid_next = 1'b0;
          end
        end
      end
      ARB_GRANT_D: begin
        if (done) begin
          grant_i = i_imem_valid;
          if (!i_imem_valid) begin
            state_next     = ARB_IDLE;
            mem_valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next     = ARB_IDLE;
        mem_valid_next = 1'b0;
      end
    endcase
    if (grant_i) begin
      state_next      = ARB_GRANT_I;
      last_grant_next = REQ_I;
      mem_valid_next  = 1'b1;
      mem_wen_next    = 1'b0;
      mem_addr_next   = i_imem_addr;
      mem_wdata_next  = '0;
    end
    if (grant_d) begin
      state_next      = ARB_GRANT_D;
      last_grant_next = REQ_D;
      mem_valid_next  = 1'b1;
      mem_wen_next    = i_dmem_wen;
      mem_addr_next   = i_dmem_addr;
      mem_wdata_next  = i_dmem_wdata;
    end
  end

  // One count per cycle in which any valid requester is not the one being served.
  always_comb begin
    waiting = (i_imem_valid && (state_reg != ARB_GRANT_I)) ||
              (i_dmem_valid && (state_reg != ARB_GRANT_D));
    stall_cnt_next = stall_cnt_reg;
    if (waiting && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + BW_STALL_CNT'(1);
    end
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= REQ_D;
      mem_valid_reg  <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      mem_valid_reg  <= mem_valid_next;
      mem_wen_reg    <= mem_wen_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

endmodule
